// File: rtl/sdram_req_arbiter.sv
// Arbitrates the CPU and video channels onto one SDRAM controller command port, one transaction at a time.
// Optional WAIT watchdog with sticky timeout_err is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_req_arbiter #(
    parameter int unsigned ADDR_W       = 25,
    parameter int unsigned CPU_MAX_LOSS = 3,
    parameter int unsigned TIMEOUT_CYC  = 255
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic              cpu_ack,
    output logic              cpu_ready,
    output logic [15:0]       cpu_dout,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_ready,
    output logic [15:0]       vid_dout,
    output logic              mem_req,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic              mem_ready,
    input  logic [15:0]       mem_dout,
    input  logic              mem_busy,
    output logic              grant_vid
`ifdef SDRAM_ARB_TIMEOUT_EN
    ,
    output logic              timeout_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] LOSS_MAX = 4'(CPU_MAX_LOSS);

    if (CPU_MAX_LOSS == 0 || CPU_MAX_LOSS > 15 || TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255) begin : g_param_check
        $error("sdram_req_arbiter: parameter out of range");
    end

    state_t     state;
    logic [3:0] loss_cnt;
    logic       rdy_pend;
    logic       vid_wins;

`ifdef SDRAM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] wait_cnt;
`endif

    always_comb begin
        vid_wins = vid_req && !(cpu_req && loss_cnt == LOSS_MAX);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= S_IDLE;
            loss_cnt  <= '0;
            rdy_pend  <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_ready <= 1'b0;
            cpu_dout  <= '0;
            vid_ack   <= 1'b0;
            vid_ready <= 1'b0;
            vid_dout  <= '0;
            mem_req   <= 1'b0;
            mem_rnw   <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            grant_vid <= 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
`endif
        end else begin
            cpu_ack   <= 1'b0;
            cpu_ready <= 1'b0;
            vid_ack   <= 1'b0;
            vid_ready <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!mem_busy && (cpu_req || vid_req)) begin
                        if (vid_wins) begin
                            grant_vid <= 1'b1;
                            mem_rnw   <= 1'b1;
                            mem_addr  <= vid_addr;
                            mem_din   <= '0;
                            if (!cpu_req)
                                loss_cnt <= '0;
                            else if (loss_cnt != LOSS_MAX)
                                loss_cnt <= loss_cnt + 4'd1;
                        end else begin
                            grant_vid <= 1'b0;
                            mem_rnw   <= cpu_rnw;
                            mem_addr  <= cpu_addr;
                            mem_din   <= cpu_din;
                            loss_cnt  <= '0;
                        end
                        mem_req  <= 1'b1;
                        rdy_pend <= 1'b0;
                        state    <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (grant_vid) vid_ack <= 1'b1;
                        else           cpu_ack <= 1'b1;
`ifdef SDRAM_ARB_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        // ack and ready together: ready is deferred one cycle and DONE is held an extra cycle
                        if (mem_ready) begin
                            if (grant_vid) vid_dout <= mem_dout;
                            else           cpu_dout <= mem_dout;
                            rdy_pend <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (mem_ready) begin
                        if (grant_vid) begin
                            vid_dout  <= mem_dout;
                            vid_ready <= 1'b1;
                        end else begin
                            cpu_dout  <= mem_dout;
                            cpu_ready <= 1'b1;
                        end
                        state <= S_DONE;
                    end
`ifdef SDRAM_ARB_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        if (grant_vid) begin
                            vid_dout  <= 16'hFFFF;
                            vid_ready <= 1'b1;
                        end else begin
                            cpu_dout  <= 16'hFFFF;
                            cpu_ready <= 1'b1;
                        end
                        timeout_err <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                S_DONE: begin
                    if (rdy_pend) begin
                        if (grant_vid) vid_ready <= 1'b1;
                        else           cpu_ready <= 1'b1;
                        rdy_pend <= 1'b0;
                    end else begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed and randomized checks of sdram_req_arbiter against a transaction-level model of the arbitration rules.
module tb_sdram_req_arbiter;
    localparam int unsigned AW   = 25;
    localparam int unsigned MAXL = 3;
    localparam int unsigned TO   = 10;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_rnw;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic          cpu_ack, cpu_ready;
    logic [15:0]   cpu_dout;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack, vid_ready;
    logic [15:0]   vid_dout;
    logic          mem_req, mem_rnw;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_ack, mem_ready, mem_busy;
    logic [15:0]   mem_dout;
    logic          grant_vid;
`ifdef SDRAM_ARB_TIMEOUT_EN
    logic          timeout_err;
`endif

    int          tests = 0;
    int          fails = 0;
    int          losses = 0;
    logic [15:0] exp_cpu_dout = '0;
    logic [15:0] exp_vid_dout = '0;
    string       order = "";

    always #5 clk_sys = ~clk_sys;

    sdram_req_arbiter #(
        .ADDR_W      (AW),
        .CPU_MAX_LOSS(MAXL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_rnw  (cpu_rnw),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_ack  (cpu_ack),
        .cpu_ready(cpu_ready),
        .cpu_dout (cpu_dout),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_ready(vid_ready),
        .vid_dout (vid_dout),
        .mem_req  (mem_req),
        .mem_rnw  (mem_rnw),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_ack  (mem_ack),
        .mem_ready(mem_ready),
        .mem_dout (mem_dout),
        .mem_busy (mem_busy),
        .grant_vid(grant_vid)
`ifdef SDRAM_ARB_TIMEOUT_EN
        ,
        .timeout_err(timeout_err)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_sys);
    endtask

    // One full transaction: model picks the winner, bench plays the controller.
    task automatic txn(input int ack_lat, input int rdy_lat, input bit both,
                       input logic [15:0] rdata, input bit hold);
        bit            exp_vid, got;
        logic [AW-1:0] ea;
        logic          erw;
        logic [7:0]    ed;
        exp_vid = vid_req && !(cpu_req && losses >= int'(MAXL));
        if (!exp_vid)      losses = 0;
        else if (!cpu_req) losses = 0;
        else if (losses < int'(MAXL)) losses = losses + 1;
        ea  = exp_vid ? vid_addr : cpu_addr;
        erw = exp_vid ? 1'b1 : cpu_rnw;
        ed  = exp_vid ? 8'h00 : cpu_din;
        order = {order, exp_vid ? "V" : "C"};

        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (mem_req) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check("grant_seen", 32'(got), 32'd1);
        if (!got) return;
        check("grant_vid", 32'(grant_vid), 32'(exp_vid));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_rnw", 32'(mem_rnw), 32'(erw));
        check("mem_din", 32'(mem_din), 32'(ed));
        for (int i = 0; i < ack_lat; i++) begin
            step();
            check("mem_req_hold", 32'(mem_req), 32'd1);
            check("mem_cmd_hold", {mem_rnw, mem_din, 23'(mem_addr)}, {erw, ed, 23'(ea)});
        end
        mem_ack = 1'b1;
        if (both) begin
            mem_ready = 1'b1;
            mem_dout  = rdata;
        end
        step();
        mem_ack   = 1'b0;
        mem_ready = 1'b0;
        check("mem_req_drop", 32'(mem_req), 32'd0);
        check("own_ack", 32'(exp_vid ? vid_ack : cpu_ack), 32'd1);
        check("other_ack", 32'(exp_vid ? cpu_ack : vid_ack), 32'd0);
        check("ready_early", 32'(cpu_ready | vid_ready), 32'd0);
        if (!hold) begin
            if (exp_vid) vid_req = 1'b0;
            else         cpu_req = 1'b0;
        end
        if (!both) begin
            for (int j = 0; j < rdy_lat; j++) begin
                step();
                check("wait_quiet", {28'd0, cpu_ack, vid_ack, cpu_ready, vid_ready}, 32'd0);
            end
            mem_ready = 1'b1;
            mem_dout  = rdata;
        end
        step();
        mem_ready = 1'b0;
        if (exp_vid) exp_vid_dout = rdata;
        else         exp_cpu_dout = rdata;
        check("own_ready", 32'(exp_vid ? vid_ready : cpu_ready), 32'd1);
        check("other_ready", 32'(exp_vid ? cpu_ready : vid_ready), 32'd0);
        check("ack_once", 32'(cpu_ack | vid_ack), 32'd0);
        check("cpu_dout", 32'(cpu_dout), 32'(exp_cpu_dout));
        check("vid_dout", 32'(vid_dout), 32'(exp_vid_dout));
        step();
        check("ready_once", 32'(cpu_ready | vid_ready), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem"}, {mem_req, mem_rnw, mem_din, 22'(mem_addr)}, 32'd0);
        check({tag, "_pulses"}, {27'd0, cpu_ack, cpu_ready, vid_ack, vid_ready, grant_vid}, 32'd0);
        check({tag, "_douts"}, {cpu_dout, vid_dout}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_rnw = 1'b0; cpu_addr = '0; cpu_din = '0;
        vid_req = 1'b0; vid_addr = '0;
        mem_ack = 1'b0; mem_ready = 1'b0; mem_dout = '0; mem_busy = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
`ifdef SDRAM_ARB_TIMEOUT_EN
        check("reset_timeout_err", 32'(timeout_err), 32'd0);
`endif
        reset = 1'b0;
        step();

        // video-only read
        vid_req = 1'b1; vid_addr = AW'(32'h01234);
        txn(2, 2, 1'b0, 16'hBEEF, 1'b0);

        // CPU write
        cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = AW'(32'h0FF00); cpu_din = 8'h5A;
        txn(3, 1, 1'b0, 16'h1111, 1'b0);

        // sustained contention
        order = "";
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = AW'(32'h00C00);
        vid_req = 1'b1; vid_addr = AW'(32'h00D00);
        for (int k = 0; k < 8; k++)
            txn(k % 3, k % 2, 1'b0, 16'(16'hA000 + k), 1'b1);
        check("contention_order", 32'(order == "VVVCVVVC"), 32'd1);
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (2) step();

        // mem_busy blocks arbitration
        mem_busy = 1'b1;
        cpu_req = 1'b1; cpu_addr = AW'(32'h00123); cpu_rnw = 1'b1;
        vid_req = 1'b1; vid_addr = AW'(32'h00456);
        for (int i = 0; i < 20; i++) begin
            step();
            check("busy_no_req", 32'(mem_req), 32'd0);
        end
        mem_busy = 1'b0;
        step();
        check("busy_release", 32'(mem_req), 32'd1);
        txn(1, 1, 1'b0, 16'h2222, 1'b0);
        txn(0, 0, 1'b0, 16'h3333, 1'b0);

        // ack and ready in the same cycle
        vid_req = 1'b1; vid_addr = AW'(32'h1ABCDE);
        txn(1, 0, 1'b1, 16'h4444, 1'b0);

        // stray controller handshakes while idle
        mem_ack = 1'b1; mem_ready = 1'b1; mem_dout = 16'hDEAD;
        step();
        mem_ack = 1'b0; mem_ready = 1'b0;
        step();
        check("stray_pulses", {27'd0, mem_req, cpu_ack, cpu_ready, vid_ack, vid_ready}, 32'd0);
        check("stray_douts", {cpu_dout, vid_dout}, {exp_cpu_dout, exp_vid_dout});

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            if (!cpu_req && $urandom_range(0, 1) == 1) begin
                cpu_req = 1'b1; cpu_rnw = 1'($urandom); cpu_addr = AW'($urandom); cpu_din = 8'($urandom);
            end
            if (!vid_req && $urandom_range(0, 1) == 1) begin
                vid_req = 1'b1; vid_addr = AW'($urandom);
            end
            if (!cpu_req && !vid_req) begin
                vid_req = 1'b1; vid_addr = AW'($urandom);
            end
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                $urandom_range(0, 3) == 0, 16'($urandom), 1'b0);
        end
        cpu_req = 1'b0; vid_req = 1'b0;
        repeat (2) step();

        // reset during WAIT
        vid_req = 1'b1; vid_addr = AW'(32'h00777);
        step();
        check("rst_grant", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; vid_req = 1'b0;
        check("rst_ack", 32'(vid_ack), 32'd1);
        step();
        reset = 1'b1;
        step();
        check_all_zero("rst_wait");
        reset = 1'b0;
        losses = 0; exp_cpu_dout = '0; exp_vid_dout = '0;
        mem_ready = 1'b1; mem_dout = 16'h9999;
        step();
        mem_ready = 1'b0;
        check("rst_no_ready", 32'(cpu_ready | vid_ready), 32'd0);
        step();
        check("rst_no_ready2", {27'd0, mem_req, cpu_ready, vid_ready, cpu_ack, vid_ack}, 32'd0);
        check("rst_douts", {cpu_dout, vid_dout}, 32'd0);

`ifdef SDRAM_ARB_TIMEOUT_EN
        cpu_req = 1'b1; cpu_rnw = 1'b1; cpu_addr = AW'(32'h00888);
        step();
        check("to_grant", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; cpu_req = 1'b0;
        check("to_ack", 32'(cpu_ack), 32'd1);
        for (int i = 1; i < int'(TO); i++) begin
            step();
            check("to_quiet", 32'(cpu_ready), 32'd0);
        end
        step();
        exp_cpu_dout = 16'hFFFF;
        check("to_ready", 32'(cpu_ready), 32'd1);
        check("to_dout", 32'(cpu_dout), 32'hFFFF);
        check("to_err", 32'(timeout_err), 32'd1);
        step();
        vid_req = 1'b1; vid_addr = AW'(32'h00999);
        txn(1, 2, 1'b0, 16'h5555, 1'b0);
        check("to_err_sticky", 32'(timeout_err), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
